// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: detects load-use hazards,
// taken branches and memory busy, and drives Mealy hold/bubble/flush controls.
module pipeline_hazard_controller #(
  parameter int LOAD_STALL_CYCLES = 2,
  parameter int FLUSH_CYCLES      = 2,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 idValid,
  input  logic [3:0]           idRn,
  input  logic [3:0]           idRm,
  input  logic [3:0]           idRs,
  input  logic                 idUsesRn,
  input  logic                 idUsesRm,
  input  logic                 idUsesRs,
  input  logic                 exValid,
  input  logic                 exLoad,
  input  logic [3:0]           exRd,
  input  logic                 exBranchTaken,
  input  logic                 memReq,
  input  logic                 memReady,
  output logic                 pcHold,
  output logic                 ifidHold,
  output logic                 rfHold,
  output logic                 rfBubble,
  output logic                 ifidFlush,
  output logic                 exmemHold,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stallCount
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  localparam int MAX_CYC = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
  // Countdown only ever holds values up to MAX_CYC-2.
  localparam int CD_W = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [CD_W-1:0] LOAD_RELOAD  = CD_W'(LOAD_STALL_CYCLES > 1 ? LOAD_STALL_CYCLES - 2 : 0);
  localparam logic [CD_W-1:0] FLUSH_RELOAD = CD_W'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);

  state_t               state_q, state_d;
  state_t               saved_q, saved_d;
  logic [CD_W-1:0]      cd_q, cd_d;
  logic [CNT_WIDTH-1:0] stall_q;

  logic hazard, mem_block, branch;
  logic pc_hold_c, ifid_hold_c, rf_hold_c, rf_bubble_c, ifid_flush_c, exmem_hold_c;

  assign hazard = exValid & exLoad & idValid &
                  ((idUsesRn & (idRn == exRd)) |
                   (idUsesRm & (idRm == exRd)) |
                   (idUsesRs & (idRs == exRd)));
  assign mem_block = memReq & ~memReady;
  assign branch    = exBranchTaken & exValid;

  // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    pc_hold_c    = 1'b0;
    ifid_hold_c  = 1'b0;
    rf_hold_c    = 1'b0;
    rf_bubble_c  = 1'b0;
    ifid_flush_c = 1'b0;
    exmem_hold_c = 1'b0;
    state_d      = state_q;
    saved_d      = saved_q;
    cd_d         = cd_q;

    if (state_q != MEM_WAIT && mem_block) begin
      // Freeze everything, including the countdown, and remember where to resume.
      pc_hold_c    = 1'b1;
      ifid_hold_c  = 1'b1;
      rf_hold_c    = 1'b1;
      exmem_hold_c = 1'b1;
      saved_d      = state_q;
      state_d      = MEM_WAIT;
    end else begin
      unique case (state_q)
        RUN: begin
          if (branch) begin
            ifid_flush_c = 1'b1;
            rf_bubble_c  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              cd_d    = FLUSH_RELOAD;
              state_d = FLUSH;
            end
          end else if (hazard) begin
            pc_hold_c   = 1'b1;
            ifid_hold_c = 1'b1;
            rf_bubble_c = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              cd_d    = LOAD_RELOAD;
              state_d = LOAD_STALL;
            end
          end
        end
        LOAD_STALL: begin
          pc_hold_c   = 1'b1;
          ifid_hold_c = 1'b1;
          rf_bubble_c = 1'b1;
          if (cd_q == '0) state_d = RUN;
          else            cd_d    = cd_q - CD_W'(1);
        end
        FLUSH: begin
          ifid_flush_c = 1'b1;
          if (cd_q == '0) state_d = RUN;
          else            cd_d    = cd_q - CD_W'(1);
        end
        MEM_WAIT: begin
          pc_hold_c    = 1'b1;
          ifid_hold_c  = 1'b1;
          rf_hold_c    = 1'b1;
          exmem_hold_c = ~memReady;
          if (memReady) state_d = saved_q;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      saved_q <= RUN;
      cd_q    <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cd_q    <= cd_d;
      if (pc_hold_c && stall_q != '1) stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  // All outputs are forced low while reset is held.
  assign pcHold     = ~reset & pc_hold_c;
  assign ifidHold   = ~reset & ifid_hold_c;
  assign rfHold     = ~reset & rf_hold_c;
  assign rfBubble   = ~reset & rf_bubble_c;
  assign ifidFlush  = ~reset & ifid_flush_c;
  assign exmemHold  = ~reset & exmem_hold_c;
  assign state      = reset ? 2'd0 : state_q;
  assign stallCount = reset ? '0 : stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; a second instance with a
// 2-bit counter shares the stimulus to exercise saturation.
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  logic reset;
  logic idValid, idUsesRn, idUsesRm, idUsesRs;
  logic [3:0] idRn, idRm, idRs, exRd;
  logic exValid, exLoad, exBranchTaken, memReq, memReady;

  logic pcHold, ifidHold, rfHold, rfBubble, ifidFlush, exmemHold;
  logic [1:0]  state;
  logic [15:0] stallCount;

  logic s_pcHold, s_ifidHold, s_rfHold, s_rfBubble, s_ifidFlush, s_exmemHold;
  logic [1:0] s_state;
  logic [1:0] s_stallCount;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller dut (
    .clk(clk), .reset(reset), .idValid(idValid),
    .idRn(idRn), .idRm(idRm), .idRs(idRs),
    .idUsesRn(idUsesRn), .idUsesRm(idUsesRm), .idUsesRs(idUsesRs),
    .exValid(exValid), .exLoad(exLoad), .exRd(exRd), .exBranchTaken(exBranchTaken),
    .memReq(memReq), .memReady(memReady),
    .pcHold(pcHold), .ifidHold(ifidHold), .rfHold(rfHold), .rfBubble(rfBubble),
    .ifidFlush(ifidFlush), .exmemHold(exmemHold), .state(state), .stallCount(stallCount)
  );

  pipeline_hazard_controller #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .idValid(idValid),
    .idRn(idRn), .idRm(idRm), .idRs(idRs),
    .idUsesRn(idUsesRn), .idUsesRm(idUsesRm), .idUsesRs(idUsesRs),
    .exValid(exValid), .exLoad(exLoad), .exRd(exRd), .exBranchTaken(exBranchTaken),
    .memReq(memReq), .memReady(memReady),
    .pcHold(s_pcHold), .ifidHold(s_ifidHold), .rfHold(s_rfHold), .rfBubble(s_rfBubble),
    .ifidFlush(s_ifidFlush), .exmemHold(s_exmemHold), .state(s_state), .stallCount(s_stallCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ctl packs {pcHold, ifidHold, rfHold, rfBubble, ifidFlush, exmemHold}.
  task automatic expect_cycle(input string tag, input logic [5:0] ctl, input logic [1:0] st);
    #1;
    check({tag, ".ctl"}, {26'd0, pcHold, ifidHold, rfHold, rfBubble, ifidFlush, exmemHold}, {26'd0, ctl});
    check({tag, ".state"}, {30'd0, state}, {30'd0, st});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idValid = 0; idRn = 0; idRm = 0; idRs = 0;
    idUsesRn = 0; idUsesRm = 0; idUsesRs = 0;
    exValid = 0; exLoad = 0; exRd = 0; exBranchTaken = 0;
    memReq = 0; memReady = 0;
  endtask

  task automatic load_use_r3();
    idle();
    exValid = 1; exLoad = 1; exRd = 4'd3;
    idValid = 1; idRn = 4'd3; idUsesRn = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    #1;
    tick();
    expect_cycle("reset_hold", 6'b000000, 2'd0);
    reset = 0;
    tick();

    // Idle for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      expect_cycle("idle", 6'b000000, 2'd0);
      check("idle.cnt", {16'd0, stallCount}, 32'd0);
      tick();
    end

    // Load-use hazard on Rn: two bubbles.
    load_use_r3();
    expect_cycle("lu0", 6'b110100, 2'd0);
    tick();
    expect_cycle("lu1", 6'b110100, 2'd1);
    tick();
    idle();
    expect_cycle("lu_done", 6'b000000, 2'd0);
    check("lu.cnt", {16'd0, stallCount}, 32'd2);
    check("lu.cnt_sat", {30'd0, s_stallCount}, 32'd2);

    // Branch with concurrent hazard: branch wins, no stall.
    load_use_r3();
    exBranchTaken = 1;
    expect_cycle("br0", 6'b000110, 2'd0);
    tick();
    idle();
    expect_cycle("br1", 6'b000010, 2'd2);
    tick();
    expect_cycle("br_done", 6'b000000, 2'd0);
    check("br.cnt", {16'd0, stallCount}, 32'd2);

    // Memory wait during LOAD_STALL, countdown resumes afterwards.
    load_use_r3();
    expect_cycle("mw_lu0", 6'b110100, 2'd0);
    tick();
    idle();
    memReq = 1; memReady = 0;
    expect_cycle("mw_enter", 6'b111001, 2'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      expect_cycle("mw_wait", 6'b111001, 2'd3);
      tick();
    end
    memReady = 1;
    expect_cycle("mw_ready", 6'b111000, 2'd3);
    tick();
    memReq = 0; memReady = 0;
    expect_cycle("mw_resume", 6'b110100, 2'd1);
    tick();
    expect_cycle("mw_done", 6'b000000, 2'd0);
    check("mw.cnt", {16'd0, stallCount}, 32'd9);
    check("mw.cnt_sat", {30'd0, s_stallCount}, 32'd3);

    // Reset in the second MEM_WAIT cycle.
    memReq = 1; memReady = 0;
    expect_cycle("rs_enter", 6'b111001, 2'd0);
    tick();
    expect_cycle("rs_wait1", 6'b111001, 2'd3);
    tick();
    reset = 1;
    expect_cycle("rs_during", 6'b000000, 2'd0);
    check("rs_during.cnt", {16'd0, stallCount}, 32'd0);
    tick();
    reset = 0;
    memReq = 0;
    expect_cycle("rs_after", 6'b000000, 2'd0);
    check("rs_after.cnt", {16'd0, stallCount}, 32'd0);

    // A matching register whose use bit is clear is ignored.
    idle();
    exValid = 1; exLoad = 1; exRd = 4'd3;
    idValid = 1; idRn = 4'd5; idUsesRn = 1; idRm = 4'd3; idUsesRm = 0;
    expect_cycle("unused_rm", 6'b000000, 2'd0);
    idRs = 4'd3; idUsesRs = 1;
    expect_cycle("used_rs", 6'b110100, 2'd0);
    idle();
    expect_cycle("nonload", 6'b000000, 2'd0);

    // Five consecutive stall cycles: small counter saturates at 3.
    load_use_r3();
    for (int i = 0; i < 5; i++) tick();
    idle();
    #1;
    check("sat.cnt16", {16'd0, stallCount}, 32'd5);
    check("sat.cnt2", {30'd0, s_stallCount}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the five-stage ARM pipeline. Each cycle it compares decode-stage source registers against the execute-stage destination, watches branch resolution and memory-stage busy status, and drives the hold, bubble and flush controls. Those controls go to the PC, the fetch/decode register, the register-fetch register (bubble = its synchronous clear) and the execute/memory register. Outputs are Mealy: decided by the registered state and the current inputs, in the same cycle.

## Interface
- LOAD_STALL_CYCLES, 2: bubbles inserted per load-use hazard (≥1).
- FLUSH_CYCLES, 2: cycles ifidFlush stays asserted per taken branch (≥1).
- CNT_WIDTH, 16: width of the stall statistics counter.

- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- idValid  in  1  decode stage holds a valid instruction.
- idRn, idRm, idRs  in  4 each  decode-stage source register numbers.
- idUsesRn, idUsesRm, idUsesRs  in  1 each  matching source is actually read.
- exValid  in  1  execute stage holds a valid instruction.
- exLoad  in  1  execute-stage instruction is a load (loadStore=1).
- exRd  in  4  execute-stage destination register.
- exBranchTaken  in  1  execute stage resolved a taken branch.
- memReq  in  1  memory stage has an access in progress.
- memReady  in  1  memory access completes this cycle.
- pcHold, ifidHold, rfHold  out  1 each  hold PC / IF-ID / register-fetch register.
- rfBubble  out  1  clear register-fetch register (inject NOP).
- ifidFlush  out  1  squash IF-ID contents.
- exmemHold  out  1  hold EX-MEM register.
- state  out  2  RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3.
- stallCount  out  CNT_WIDTH  cycles with pcHold=1, saturating.

## Operation
- Registered state: state, savedState (2b), countdown (enough bits for max(LOAD_STALL_CYCLES, FLUSH_CYCLES)), stallCount.
- hazard = exValid & exLoad & idValid & ((idUsesRn & idRn==exRd) | (idUsesRm & idRm==exRd) | (idUsesRs & idRs==exRd)).
- memBlock = memReq & !memReady.
- Priority within any non-MEM_WAIT state: memBlock > exBranchTaken (with exValid) > hazard.
- memBlock in RUN, LOAD_STALL or FLUSH: assert pcHold, ifidHold, rfHold and exmemHold. Suppress rfBubble and ifidFlush. Freeze countdown. savedState ← current state. Next state MEM_WAIT.
- MEM_WAIT: pcHold = ifidHold = rfHold = 1 every cycle; exmemHold = !memReady. On memReady the next state is savedState, and countdown resumes its frozen value. RUN re-evaluates hazard and branch from scratch.
- RUN, taken branch: ifidFlush = rfBubble = 1. If FLUSH_CYCLES>1, countdown ← FLUSH_CYCLES-2 and next state FLUSH; otherwise stay in RUN.
- RUN, hazard (no branch): pcHold = ifidHold = rfBubble = 1. If LOAD_STALL_CYCLES>1, countdown ← LOAD_STALL_CYCLES-2 and next state LOAD_STALL.
- LOAD_STALL: pcHold = ifidHold = rfBubble = 1. At countdown==0 go to RUN, else decrement.
- FLUSH: ifidFlush = 1, no holds. At countdown==0 go to RUN, else decrement.
- Every output not named for a state is 0.
- stallCount increments on each posedge where pcHold=1; it saturates at all ones and never wraps.

## Timing
- Zero-latency controls: outputs respond combinationally in the cycle the condition is present.
- Load-use costs exactly LOAD_STALL_CYCLES bubbles. A taken branch costs exactly FLUSH_CYCLES flush cycles. Both exclude any MEM_WAIT cycles inserted.
- MEM_WAIT length = cycles until memReady, including the memReady cycle.
- While reset=1: all outputs 0. On the posedge with reset=1: state, savedState and countdown ← RUN/0, stallCount ← 0. Reset mid-stall, mid-flush or mid-wait abandons the sequence; the first cycle after reset is in RUN.
- Simultaneous branch and hazard: branch wins. The hazard instruction is squashed and no stall occurs.
- Hazard on a source register whose idUses bit is 0: ignored.

## Test plan
- Reset, then idle inputs for 5 cycles: all outputs 0, state=0, stallCount=0.
- LDR r3 in EX, decode uses Rn=r3 (defaults): pcHold and rfBubble high for exactly 2 cycles with states 0→1→0, then stallCount=2.
- exBranchTaken pulse with a concurrent r3 hazard: ifidFlush high for 2 cycles, rfBubble only in the first, pcHold never set, stallCount unchanged.
- During LOAD_STALL, memReq=1 with memReady low for 3 cycles then high: state 1→3 (4 cycles)→1 with countdown resumed, then 1 more bubble cycle. exmemHold is low only in the memReady cycle.
- Reset asserted in the second MEM_WAIT cycle: outputs 0 immediately, next cycle state=0, stallCount=0.
- CNT_WIDTH=2, 5 consecutive stall cycles: stallCount saturates at 3.
